// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit counter width: must reach w-1 without wrapping.
    function automatic int cnt_width(input int w);
        int cw;
        cw = (w > 1) ? $clog2(w) : 1;
        if ((1 << cw) < w) cw = cw + 1;
        return cw;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// One-bit combinational full adder, reused for every bit of a serial addition.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one bit pair per cycle, LSB first, through a single fa_cell.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.
//
//   state | meaning
//   IDLE  | waiting for start, result registers hold last completion
//   RUN   | one bit pair added per cycle, WIDTH cycles total
//   DONE  | single-cycle completion; start here chains the next addition
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] op_a, op_b, part, part_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_co;
    logic             accept, last_bit;

    assign accept   = start && (state != RUN);
    assign last_bit = (state == RUN) && (cnt == LAST);
    // New sum bit enters from the MSB side so the LSB lands at bit 0 after WIDTH shifts.
    assign part_nxt = (part >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    fa_cell u_fa (
        .a  (op_a[0]),
        .b  (op_b[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            part  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= b;
            part  <= '0;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            part  <= part_nxt;
            carry <= fa_co;
            if (!last_bit) cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (last_bit) begin
            sum  <= part_nxt;
            cout <= fa_co;
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    // On the last bit, carry holds the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        ovf <= 1'b0;
        else if (last_bit) ovf <= carry ^ fa_co;
    end
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8); checks ovf when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int n_chk = 0;
    int n_err = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
        .cout  (cout),
        .ovf   (ovf)
`else
        .cout  (cout)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one edge; returns in cycle 1 of the operation.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // From cycle 1, walk the WIDTH busy cycles and check the DONE cycle.
    // inject: hold start with new operands during cycles 3..5.
    task automatic run_to_done(input string tag, input logic [W-1:0] exp_sum,
                               input logic exp_cout, input logic exp_ovf, input bit inject);
        int busy_n = 0;
        int done_n = 0;
        int both_n = 0;
        for (int i = 1; i <= W; i++) begin
            if (inject && i == 3) begin
                start = 1'b1;
                a     = 8'hAA;
                b     = 8'h55;
                cin   = 1'b1;
            end
            if (inject && i == 6) start = 1'b0;
            busy_n += int'(busy);
            done_n += int'(done);
            both_n += int'(busy && done);
            tick();
        end
        chk({tag, "_busy_cycles"}, busy_n, W);
        chk({tag, "_early_done"}, done_n, 0);
        chk({tag, "_busy_done_overlap"}, both_n, 0);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy_at_done"}, busy, 1'b0);
        chk({tag, "_sum"}, sum, exp_sum);
        chk({tag, "_cout"}, cout, exp_cout);
`ifdef SERIAL_ADD_OVF_EN
        chk({tag, "_ovf"}, ovf, exp_ovf);
`else
        if (exp_ovf === 1'bx) chk({tag, "_ovf_arg"}, exp_ovf, 1'b0);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sum", sum, 8'h00);
        chk("rst_cout", cout, 1'b0);
        repeat (2) tick();

        // First start right after reset release is accepted on the next edge.
        rst_n = 1'b1;
        launch(8'h03, 8'h05, 1'b0);
        run_to_done("add_03_05", 8'h08, 1'b0, 1'b0, 1'b0);
        tick();
        chk("idle_after_done_busy", busy, 1'b0);
        chk("idle_after_done_done", done, 1'b0);
        chk("sum_held", sum, 8'h08);

        launch(8'hFF, 8'h01, 1'b0);
        run_to_done("add_ff_01", 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        launch(8'h7F, 8'h01, 1'b0);
        run_to_done("add_7f_01", 8'h80, 1'b0, 1'b1, 1'b0);
        tick();
        launch(8'hFF, 8'hFF, 1'b1);
        run_to_done("add_ff_ff_c", 8'hFF, 1'b1, 1'b0, 1'b0);
        tick();
        launch(8'h00, 8'h00, 1'b1);
        run_to_done("add_00_00_c", 8'h01, 1'b0, 1'b0, 1'b0);
        tick();

        // start ignored while running
        launch(8'h12, 8'h34, 1'b0);
        run_to_done("ignore_start", 8'h46, 1'b0, 1'b0, 1'b1);
        tick();
        chk("ignore_no_second_busy", busy, 1'b0);
        chk("ignore_no_second_done", done, 1'b0);
        chk("ignore_sum_held", sum, 8'h46);

        // reset in cycle 4 of RUN
        launch(8'h03, 8'h05, 1'b0);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_sum", sum, 8'h00);
        chk("abort_cout", cout, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        chk("abort_sum_after_release", sum, 8'h00);
        launch(8'h21, 8'h0F, 1'b1);
        run_to_done("after_abort", 8'h31, 1'b0, 1'b0, 1'b0);
        tick();

        // back-to-back: start in the DONE cycle
        launch(8'h40, 8'h41, 1'b0);
        run_to_done("b2b_first", 8'h81, 1'b0, 1'b1, 1'b0);
        a     = 8'h10;
        b     = 8'h20;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_to_done("b2b_second", 8'h30, 1'b0, 1'b0, 1'b0);
        tick();
        chk("b2b_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
